// File: rtl/index_bitmap_pkg.sv
// Shared types and default widths for the index-to-bitmap builder.
package index_bitmap_pkg;

    localparam int unsigned DATA_WD_DEF = 8;
    localparam int unsigned IND_WD_DEF  = $clog2(DATA_WD_DEF);
    localparam int unsigned CNT_WD_DEF  = $clog2(DATA_WD_DEF + 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Frame payload at the default width: bitmap, popcount and error flags.
    typedef struct packed {
        logic [DATA_WD_DEF-1:0] map;
        logic [CNT_WD_DEF-1:0]  cnt;
        logic                   dup;
        logic                   oor;
    } bitmap_frame_t;

endpackage

// File: rtl/index_decoder.sv
// Combinational index-to-one-hot decode with an out-of-range flag.
module index_decoder
    import index_bitmap_pkg::*;
#(
    parameter int unsigned DATA_WD = DATA_WD_DEF,
    parameter int unsigned IND_WD  = $clog2(DATA_WD)
) (
    input  logic [IND_WD-1:0]  i_idx,
    output logic [DATA_WD-1:0] o_bit,
    output logic               o_oor
);

    // Indices past the top bit shift the one out entirely, giving all zeros.
    assign o_oor = (32'(i_idx) >= DATA_WD);
    assign o_bit = DATA_WD'(1) << i_idx;

endmodule

// File: rtl/index_to_bitmap_builder.sv
// Accumulates a stream of bit indices into a bitmap per frame and presents
// each completed frame in a registered valid/ready output slot.
module index_to_bitmap_builder
    import index_bitmap_pkg::*;
#(
    parameter int unsigned DATA_WD = DATA_WD_DEF,
    parameter int unsigned IND_WD  = $clog2(DATA_WD),
    parameter int unsigned CNT_WD  = $clog2(DATA_WD + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_idx_valid,
    output logic               o_idx_ready,
    input  logic [IND_WD-1:0]  i_idx,
    input  logic               i_idx_last,
    output logic               o_map_valid,
    input  logic               i_map_ready,
    output logic [DATA_WD-1:0] o_map,
    output logic [CNT_WD-1:0]  o_map_cnt,
    output logic               o_map_dup,
    output logic               o_map_oor
);

    typedef struct packed {
        logic [DATA_WD-1:0] map;
        logic [CNT_WD-1:0]  cnt;
        logic               dup;
        logic               oor;
    } frame_t;

    out_state_e         r_state;
    out_state_e         w_state_nxt;
    frame_t             r_acc;
    frame_t             r_out;
    frame_t             w_acc_upd;
    logic [DATA_WD-1:0] w_bit;
    logic               w_oor;
    logic               w_hs_in;
    logic               w_close;

    index_decoder #(
        .DATA_WD (DATA_WD),
        .IND_WD  (IND_WD)
    ) u_dec (
        .i_idx (i_idx),
        .o_bit (w_bit),
        .o_oor (w_oor)
    );

    // The slot can take a new frame whenever it is empty or being drained.
    assign o_idx_ready = (r_state == ST_EMPTY) || i_map_ready;
    assign w_hs_in     = i_idx_valid && o_idx_ready;
    assign w_close     = w_hs_in && i_idx_last;

    // Accumulator after this beat; the count only moves on a newly set bit.
    always_comb begin
        w_acc_upd = r_acc;
        if (w_oor) begin
            w_acc_upd.oor = 1'b1;
        end else if ((r_acc.map & w_bit) != '0) begin
            w_acc_upd.dup = 1'b1;
        end else begin
            w_acc_upd.map = r_acc.map | w_bit;
            w_acc_upd.cnt = r_acc.cnt + CNT_WD'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (w_close) begin
            r_acc <= '0;
        end else if (w_hs_in) begin
            r_acc <= w_acc_upd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else if (w_close) begin
            r_out <= w_acc_upd;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A closing beat always refills the slot, even while it is being drained.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_close) w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (i_map_ready && !w_close) w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    assign o_map_valid = (r_state == ST_FULL);
    assign o_map       = r_out.map;
    assign o_map_cnt   = r_out.cnt;
    assign o_map_dup   = r_out.dup;
    assign o_map_oor   = r_out.oor;

endmodule

// File: tb/tb_index_to_bitmap_builder.sv
// Directed bench: an 8-bit and a 6-bit builder share one index stream.
module tb_index_to_bitmap_builder;
    import index_bitmap_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       idx_valid;
    logic [2:0] idx;
    logic       idx_last;
    logic       map_ready;

    logic       rdy8, mv8, dup8, oor8;
    logic [7:0] map8;
    logic [3:0] cnt8;
    logic       rdy6, mv6, dup6, oor6;
    logic [5:0] map6;
    logic [2:0] cnt6;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    index_to_bitmap_builder u_dut8 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_idx_valid (idx_valid),
        .o_idx_ready (rdy8),
        .i_idx       (idx),
        .i_idx_last  (idx_last),
        .o_map_valid (mv8),
        .i_map_ready (map_ready),
        .o_map       (map8),
        .o_map_cnt   (cnt8),
        .o_map_dup   (dup8),
        .o_map_oor   (oor8)
    );

    index_to_bitmap_builder #(.DATA_WD(6)) u_dut6 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_idx_valid (idx_valid),
        .o_idx_ready (rdy6),
        .i_idx       (idx),
        .i_idx_last  (idx_last),
        .o_map_valid (mv6),
        .i_map_ready (map_ready),
        .o_map       (map6),
        .o_map_cnt   (cnt6),
        .o_map_dup   (dup6),
        .o_map_oor   (oor6)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_frame8(input string tag, input bitmap_frame_t exp);
        bitmap_frame_t act;
        act = '{map: map8, cnt: cnt8, dup: dup8, oor: oor8};
        check_eq(tag, 32'(act), 32'(exp));
    endtask

    // Called at a negedge; presents one beat, waits for its handshake, returns at the next negedge.
    task automatic send(input logic [2:0] idx_v, input logic last_v);
        int unsigned budget = 0;
        idx_valid = 1'b1;
        idx       = idx_v;
        idx_last  = last_v;
        while (!rdy8 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check_eq("send_ready", 32'(rdy8), 32'd1);
        @(posedge clk);
        @(negedge clk);
        idx_valid = 1'b0;
        idx_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        idx_valid = 1'b0;
        idx       = '0;
        idx_last  = 1'b0;
        map_ready = 1'b1;
        #1;
        check_eq("rst_valid", 32'(mv8), 32'd0);
        check_frame8("rst_frame", '{map: 8'h00, cnt: 4'd0, dup: 1'b0, oor: 1'b0});
        check_eq("rst_ready", 32'(rdy8), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Frame {0,3,7}: valid only in the cycle after the closing beat
        send(3'd0, 1'b0);
        send(3'd3, 1'b0);
        check_eq("f1_valid_early", 32'(mv8), 32'd0);
        send(3'd7, 1'b1);
        check_eq("f1_valid", 32'(mv8), 32'd1);
        check_frame8("f1_frame", '{map: 8'h89, cnt: 4'd3, dup: 1'b0, oor: 1'b0});
        @(negedge clk);
        check_eq("f1_valid_drop", 32'(mv8), 32'd0);

        // Single-beat frames back to back; bit 5 must not leak into the second
        send(3'd5, 1'b1);
        check_frame8("f2_frame", '{map: 8'h20, cnt: 4'd1, dup: 1'b0, oor: 1'b0});
        send(3'd1, 1'b1);
        check_eq("f3_valid", 32'(mv8), 32'd1);
        check_frame8("f3_frame", '{map: 8'h02, cnt: 4'd1, dup: 1'b0, oor: 1'b0});

        // Duplicate index, then a clean frame with dup cleared
        send(3'd2, 1'b0);
        send(3'd2, 1'b0);
        send(3'd4, 1'b1);
        check_frame8("f4_frame", '{map: 8'h14, cnt: 4'd2, dup: 1'b1, oor: 1'b0});
        send(3'd0, 1'b1);
        check_frame8("f5_frame", '{map: 8'h01, cnt: 4'd1, dup: 1'b0, oor: 1'b0});
        @(negedge clk);

        // Backpressure hold, then drain and refill in the same cycle
        map_ready = 1'b0;
        send(3'd6, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_ready", 32'(rdy8), 32'd0);
            check_eq("bp_valid", 32'(mv8), 32'd1);
            check_eq("bp_map", 32'(map8), 32'h40);
            @(negedge clk);
        end
        map_ready = 1'b1;
        idx_valid = 1'b1;
        idx       = 3'd1;
        idx_last  = 1'b1;
        #1;
        check_eq("bp_ready_up", 32'(rdy8), 32'd1);
        check_eq("bp_taken_map", 32'(map8), 32'h40);
        @(posedge clk);
        @(negedge clk);
        idx_valid = 1'b0;
        idx_last  = 1'b0;
        check_eq("bp_refill_valid", 32'(mv8), 32'd1);
        check_frame8("bp_refill_frame", '{map: 8'h02, cnt: 4'd1, dup: 1'b0, oor: 1'b0});
        @(negedge clk);
        check_eq("bp_drained", 32'(mv8), 32'd0);

        // Indices 6 and 7 are out of range for the 6-bit builder only
        send(3'd6, 1'b0);
        send(3'd7, 1'b0);
        send(3'd2, 1'b1);
        check_eq("w6_valid", 32'(mv6), 32'd1);
        check_eq("w6_map", 32'(map6), 32'h04);
        check_eq("w6_cnt", 32'(cnt6), 32'd1);
        check_eq("w6_oor", 32'(oor6), 32'd1);
        check_eq("w6_dup", 32'(dup6), 32'd0);
        check_frame8("w8_frame", '{map: 8'hC4, cnt: 4'd3, dup: 1'b0, oor: 1'b0});
        @(negedge clk);

        // Asynchronous reset mid-frame discards the partial accumulation
        send(3'd1, 1'b0);
        send(3'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(mv8), 32'd0);
        check_frame8("arst_frame", '{map: 8'h00, cnt: 4'd0, dup: 1'b0, oor: 1'b0});
        check_eq("arst_map6", 32'({mv6, map6, cnt6, dup6, oor6}), 32'd0);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        send(3'd0, 1'b1);
        check_eq("post_rst_valid", 32'(mv8), 32'd1);
        check_frame8("post_rst_frame", '{map: 8'h01, cnt: 4'd1, dup: 1'b0, oor: 1'b0});
        check_eq("post_rst_map6", 32'(map6), 32'h01);
        check_eq("post_rst_cnt6", 32'(cnt6), 32'd1);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
